// File: rtl/count_seq_checker.sv
// count_seq_checker: receive-side checker for a free-running counter stream.
// Tracks an N-bit count bus qualified by sample_valid and expects it to advance
// by +1 modulo 2^WIDTH. It locks after LOCK_LEN consecutive good samples that
// follow a seed sample. While locked it counts mismatches in a saturating
// counter, and it drops lock after LOSS_LEN consecutive mismatches.
//
// Optional feature macro: SEQ_CHK_HOLD_EN. When it is defined, a sample equal
// to expected-1 while tracking or locked is treated as a stalled counter (hold).
// A hold changes nothing. When the macro is undefined, such a sample is an
// ordinary mismatch.
//
// Handshake: sample_valid is a one-sided qualifier with no ready. A sample is
// consumed on every rising edge where sample_valid=1. All outputs are
// registered and reflect that sample one cycle later.
module count_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int LOCK_LEN = 4,
    parameter int LOSS_LEN = 2,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] SEARCH = 2'b00;
    localparam logic [1:0] TRACK  = 2'b01;
    localparam logic [1:0] LOCKED = 2'b10;

    localparam int MW = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);
    localparam int LW = (LOSS_LEN < 2) ? 1 : $clog2(LOSS_LEN + 1);
    localparam logic [MW-1:0] LOCK_CMP = MW'(LOCK_LEN);
    localparam logic [LW-1:0] LOSS_CMP = LW'(LOSS_LEN);

    logic [1:0]       state;
    logic [MW-1:0]    match_cnt;
    logic [LW-1:0]    miss_cnt;
    logic [MW-1:0]    match_nxt;
    logic [LW-1:0]    miss_nxt;
    logic [WIDTH-1:0] exp_seed;
    logic [WIDTH-1:0] exp_inc;
    logic             is_match;
    logic             hold;
    logic             err_sat;

    assign state_dbg = state;
    assign match_nxt = match_cnt + MW'(1);
    assign miss_nxt  = miss_cnt + LW'(1);
    assign exp_seed  = sample + WIDTH'(1);
    assign exp_inc   = expected + WIDTH'(1);
    assign is_match  = (sample == expected);
    assign err_sat   = &err_count;

`ifdef SEQ_CHK_HOLD_EN
    // A stalled counter repeats the last value, which sits one below expected.
    assign hold = (sample == expected - WIDTH'(1));
`else
    assign hold = 1'b0;
`endif

    // Sequence-tracking FSM, error counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            expected  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clear) begin
                err_count <= '0;
            end
            if (sample_valid) begin
                case (state)
                    SEARCH: begin
                        expected  <= exp_seed;
                        match_cnt <= '0;
                        state     <= TRACK;
                    end
                    TRACK: begin
                        if (hold) begin
                            expected <= expected;
                        end else if (is_match) begin
                            expected  <= exp_inc;
                            match_cnt <= match_nxt;
                            if (match_nxt == LOCK_CMP) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            // Resynchronise onto the new value; errors are not counted before lock.
                            expected  <= exp_seed;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (hold) begin
                            expected <= expected;
                        end else if (is_match) begin
                            expected <= exp_inc;
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            // clear takes priority over a same-cycle increment.
                            if (!clear && !err_sat) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            expected <= exp_seed;
                            if (miss_nxt == LOSS_CMP) begin
                                state     <= TRACK;
                                locked    <= 1'b0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_nxt;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
